// File: rtl/comb_decim_pkg.sv
// Shared constants for the comb decimator: parameter legality limits,
// synchroniser depth and a helper that sizes the phase counter.
package comb_decim_pkg;

    localparam int DECIM_RATIO_MIN = 1;
    localparam int DECIM_RATIO_MAX = 256;
    localparam int DIFF_DELAY_MIN  = 1;
    localparam int DIFF_DELAY_MAX  = 2;
    localparam int SYNC_STAGES     = 2;

    // Phase counter width; a ratio of 1 still keeps a 1-bit counter that
    // never leaves 0.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/comb_decim_edge.sv
// clk_edge_det: brings the CLK_I sample clock into the master clock domain
// as data and derives one-cycle rising (o_stb) and falling (o_fstb) strobes.
// Ports:
//   i_mclk   master clock
//   i_rst_n  asynchronous active-low reset
//   i_clk_in raw sample clock (treated as data)
//   o_stb    1-cycle strobe after a synchronised rising edge
//   o_fstb   1-cycle strobe after a synchronised falling edge
module clk_edge_det
    import comb_decim_pkg::*;
(
    input  logic i_mclk,
    input  logic i_rst_n,
    input  logic i_clk_in,
    output logic o_stb,
    output logic o_fstb
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Flops come out of reset high so a sample clock that is already high
    // at release is not mistaken for a fresh rising edge.
    always_ff @(posedge i_mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_clk_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_stb  =  r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fstb = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule

// File: rtl/comb_decim.sv
// comb_decim: decimating comb stage of a CIC filter. Every R-th sample
// strobe is accepted; the output is the modular difference between the
// accepted sample and the one accepted M acceptances earlier, with
// overflow/underflow flags. A decimated sample clock is produced in the
// master clock domain.
// Ports:
//   MCLK_I   master clock          NRST_I  async active-low reset
//   CLK_I    input sample clock    DATA_I  signed input sample
//   CLK_O    decimated clock       DATA_O  signed comb output
//   OFDET_O  positive wrap flag    UFDET_O negative wrap flag
module comb_decim
    import comb_decim_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = 5,
    parameter int DECIM_RATIO    = 4,
    parameter int DIFF_DELAY     = 1
) (
    input  logic                             MCLK_I,
    input  logic                             NRST_I,
    input  logic                             CLK_I,
    input  logic signed [DATA_BIT_WIDTH-1:0] DATA_I,
    output logic                             CLK_O,
    output logic signed [DATA_BIT_WIDTH-1:0] DATA_O,
    output logic                             OFDET_O,
    output logic                             UFDET_O
);

    localparam int W     = DATA_BIT_WIDTH;
    localparam int CNT_W = cnt_width(DECIM_RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM_RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DECIM_RATIO / 2);

    if (DECIM_RATIO < DECIM_RATIO_MIN || DECIM_RATIO > DECIM_RATIO_MAX) begin : g_bad_ratio
        $error("comb_decim: DECIM_RATIO %0d out of range", DECIM_RATIO);
    end
    if (DIFF_DELAY < DIFF_DELAY_MIN || DIFF_DELAY > DIFF_DELAY_MAX) begin : g_bad_delay
        $error("comb_decim: DIFF_DELAY %0d out of range", DIFF_DELAY);
    end

    logic             w_stb;
    logic             w_fstb;
    logic             w_accept;
    logic             w_clk_fall;
    logic [CNT_W-1:0] w_cnt_next;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_xd;

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_dly [DIFF_DELAY];
    logic [W-1:0]     r_data;
    logic             r_of;
    logic             r_uf;
    logic             r_acc_d;
    logic             r_clk_o;

    clk_edge_det u_edge (
        .i_mclk  (MCLK_I),
        .i_rst_n (NRST_I),
        .i_clk_in(CLK_I),
        .o_stb   (w_stb),
        .o_fstb  (w_fstb)
    );

    assign w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    assign w_accept   = w_stb && (r_cnt == CNT_LAST);
    assign w_xd       = r_dly[DIFF_DELAY-1];

    // One extra bit keeps the true difference so the wrap direction is
    // visible in the top two bits.
    assign w_diff = {DATA_I[W-1], DATA_I} - {w_xd[W-1], w_xd};

    // R=1 has no mid-cycle counter phase, so the input falling edge ends
    // the output high phase instead.
    assign w_clk_fall = (DECIM_RATIO == 1) ? w_fstb
                                           : (w_stb && (w_cnt_next == CNT_HALF));

    always_ff @(posedge MCLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            r_cnt   <= '0;
            r_data  <= '0;
            r_of    <= 1'b0;
            r_uf    <= 1'b0;
            r_acc_d <= 1'b0;
            r_clk_o <= 1'b0;
            for (int i = 0; i < DIFF_DELAY; i++) r_dly[i] <= '0;
        end else begin
            r_acc_d <= w_accept;
            if (w_stb) r_cnt <= w_cnt_next;
            if (w_accept) begin
                r_dly[0] <= DATA_I;
                for (int i = 1; i < DIFF_DELAY; i++) r_dly[i] <= r_dly[i-1];
                r_data <= w_diff[W-1:0];
                r_of   <= ~w_diff[W] &  w_diff[W-1];
                r_uf   <=  w_diff[W] & ~w_diff[W-1];
            end
            // Rise takes priority over a coincident fall.
            if (r_acc_d)         r_clk_o <= 1'b1;
            else if (w_clk_fall) r_clk_o <= 1'b0;
        end
    end

    assign DATA_O  = r_data;
    assign OFDET_O = r_of;
    assign UFDET_O = r_uf;
    assign CLK_O   = r_clk_o;

endmodule

// File: tb/tb_comb_decim.sv
`timescale 1ns/100ps
module tb_comb_decim;

    logic              mclk = 1'b0;
    logic              rst_n;
    logic              clk_i;
    logic signed [4:0] data_i;

    logic              clk_o4, of4, uf4;
    logic signed [4:0] data_o4;
    logic              clk_o1, of1, uf1;
    logic signed [4:0] data_o1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: samples since reset, last accepted value and
    // the expected visible outputs of each instance.
    int k4, prev4, e_out4, e_of4, e_uf4, e_clk4;
    int prev1, e_out1, e_of1, e_uf1;

    always #1 mclk = ~mclk;

    comb_decim #(.DATA_BIT_WIDTH(5), .DECIM_RATIO(4), .DIFF_DELAY(1)) dut (
        .MCLK_I (mclk), .NRST_I (rst_n), .CLK_I (clk_i), .DATA_I (data_i),
        .CLK_O  (clk_o4), .DATA_O (data_o4), .OFDET_O(of4), .UFDET_O(uf4)
    );

    comb_decim #(.DATA_BIT_WIDTH(5), .DECIM_RATIO(1), .DIFF_DELAY(1)) dut_r1 (
        .MCLK_I (mclk), .NRST_I (rst_n), .CLK_I (clk_i), .DATA_I (data_i),
        .CLK_O  (clk_o1), .DATA_O (data_o1), .OFDET_O(of1), .UFDET_O(uf1)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wrap5(input int d);
        int w;
        w = d & 31;
        if (w > 15) w -= 32;
        return w;
    endfunction

    function automatic int rnd5();
        return int'($urandom_range(31)) - 16;
    endfunction

    task automatic model_reset();
        k4 = 0; prev4 = 0; e_out4 = 0; e_of4 = 0; e_uf4 = 0; e_clk4 = 0;
        prev1 = 0; e_out1 = 0; e_of1 = 0; e_uf1 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_d4"}, int'(data_o4), 0);
        check_val({tag, "_of4"}, int'(of4), 0);
        check_val({tag, "_uf4"}, int'(uf4), 0);
        check_val({tag, "_clk4"}, int'(clk_o4), 0);
        check_val({tag, "_d1"}, int'(data_o1), 0);
        check_val({tag, "_of1"}, int'(of1), 0);
        check_val({tag, "_uf1"}, int'(uf1), 0);
        check_val({tag, "_clk1"}, int'(clk_o1), 0);
    endtask

    // One full input sample period (16 MCLK high, 17 low), entered and left
    // on a falling MCLK edge with clk_i low.
    task automatic send(input int x);
        int  k_cur;
        int  d;
        bit  acc4;
        data_i = 5'(x);
        @(negedge mclk);
        clk_i = 1'b1;
        k_cur = k4;
        acc4  = ((k_cur % 4) == 3);
        repeat (2) @(negedge mclk);
        check_val("hold_d4", int'(data_o4), e_out4);
        check_val("hold_d1", int'(data_o1), e_out1);
        check_val("hold_clk1", int'(clk_o1), 0);
        @(negedge mclk);
        if (acc4) begin
            d = x - prev4; prev4 = x;
            e_out4 = wrap5(d); e_of4 = int'(d > 15); e_uf4 = int'(d < -16);
        end
        if ((k_cur % 4) == 1) e_clk4 = 0;
        d = x - prev1; prev1 = x;
        e_out1 = wrap5(d); e_of1 = int'(d > 15); e_uf1 = int'(d < -16);
        k4++;
        check_val("data4", int'(data_o4), e_out4);
        check_val("of4", int'(of4), e_of4);
        check_val("uf4", int'(uf4), e_uf4);
        check_val("clk4_a", int'(clk_o4), e_clk4);
        check_val("data1", int'(data_o1), e_out1);
        check_val("of1", int'(of1), e_of1);
        check_val("uf1", int'(uf1), e_uf1);
        check_val("clk1_pre", int'(clk_o1), 0);
        @(negedge mclk);
        if (acc4) e_clk4 = 1;
        check_val("clk4_b", int'(clk_o4), e_clk4);
        check_val("clk1_rise", int'(clk_o1), 1);
        repeat (12) begin
            @(negedge mclk);
            check_val("clk1_high", int'(clk_o1), 1);
            check_val("data1_stable", int'(data_o1), e_out1);
        end
        clk_i = 1'b0;
        repeat (2) @(negedge mclk);
        check_val("clk1_hold", int'(clk_o1), 1);
        @(negedge mclk);
        check_val("clk1_fall", int'(clk_o1), 0);
        check_val("clk4_low", int'(clk_o4), e_clk4);
        repeat (13) @(negedge mclk);
    endtask

    task automatic send_group(input int acc_val);
        repeat (3) send(rnd5());
        send(acc_val);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n  = 1'b0;
        clk_i  = 1'b0;
        data_i = '0;
        model_reset();
        #5;
        check_all_zero("rst0");
        @(negedge mclk);
        rst_n = 1'b1;
        repeat (4) @(negedge mclk);

        // Ramp input: 3 at first acceptance, 4 afterwards.
        for (int i = 0; i < 12; i++) send(i);
        check_val("ramp_last", int'(data_o4), 4);
        check_val("ramp_of", int'(of4), 0);

        // Positive and negative wrap, then wrap-through.
        send_group(-16);
        send_group(15);
        check_val("ovf_data", int'(data_o4), -1);
        check_val("ovf_of", int'(of4), 1);
        check_val("ovf_uf", int'(uf4), 0);
        send_group(-16);
        check_val("unf_data", int'(data_o4), 1);
        check_val("unf_uf", int'(uf4), 1);
        send_group(14);
        send_group(-14);
        check_val("wrapthru_data", int'(data_o4), 4);
        check_val("wrapthru_uf", int'(uf4), 1);

        for (int g = 0; g < 40; g++) send(rnd5());

        // Reset mid-stream, out of phase with the decimation counter.
        send(rnd5());
        send(rnd5());
        @(negedge mclk);
        rst_n = 1'b0;
        #0.5;
        check_all_zero("rst_mid");
        #19.5;
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge mclk);
        repeat (3) send(rnd5());
        send(7);
        check_val("rst_first_acc", int'(data_o4), 7);

        // Sample clock held high through reset release.
        send(rnd5());
        @(negedge mclk);
        rst_n = 1'b0;
        @(negedge mclk);
        clk_i = 1'b1;
        data_i = 5'(9);
        repeat (5) @(negedge mclk);
        rst_n = 1'b1;
        model_reset();
        repeat (20) @(negedge mclk);
        check_all_zero("hi_release");
        clk_i = 1'b0;
        repeat (16) @(negedge mclk);
        check_all_zero("hi_low");
        send(5);
        send(-3);
        send(2);
        send(-8);
        check_val("hi_first_acc", int'(data_o4), -8);
        for (int g = 0; g < 12; g++) send(rnd5());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
